// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Parameterised ripple-carry adder. It has two result paths:
//     * combinational: sum/cout follow a, b and cin with no clock involved
//     * registered:    sum_q/cout_q/out_valid capture the result one cycle
//                      after in_valid
//   Optional feature (define FULL_ADDER_STATS_EN):
//     adds cout_cnt, a 16-bit saturating count of valid carry-outs.
//   Reset is synchronous and active-low (rst_n sampled on the rising clk edge).
// ---------------------------------------------------------------------------
module full_adder #(
  parameter int unsigned WIDTH = 1  // operand width, 1..64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
`ifdef FULL_ADDER_STATS_EN
  ,
  output logic [15:0]      cout_cnt
`endif
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  logic [WIDTH-1:0] r_sum_q;
  logic             r_cout_q;
  logic             r_out_valid;

  // Ripple chain: each bit is a classic single-bit full adder whose carry
  // feeds the next bit up.
  always_comb begin : ripple
    logic w_c;
    // NOTE: a blocking carry variable inside always_comb threads the carry
    // bit-to-bit within one evaluation; every output gets a value on every
    // pass, so no latch is inferred.
    w_c   = cin;
    w_sum = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_sum[i] = a[i] ^ b[i] ^ w_c;
      w_c      = (a[i] & b[i]) | (a[i] & w_c) | (b[i] & w_c);
    end
    w_cout = w_c;
  end

  assign sum  = w_sum;
  assign cout = w_cout;

  // Registered result path: capture on in_valid, otherwise hold the data
  // and drop the valid flag.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it sits inside the clocked branch
    // and only acts on a rising edge; the sensitivity list has clk alone.
    if (!rst_n) begin
      r_sum_q     <= '0;
      r_cout_q    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge
      // values, independent of statement order.
      r_sum_q     <= w_sum;
      r_cout_q    <= w_cout;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign sum_q     = r_sum_q;
  assign cout_q    = r_cout_q;
  assign out_valid = r_out_valid;

`ifdef FULL_ADDER_STATS_EN
  logic [15:0] r_cout_cnt;

  // Saturating count of carry-outs seen on accepted operand sets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cout_cnt <= '0;
    end else if (in_valid && w_cout && (r_cout_cnt != CNT_MAX)) begin
      r_cout_cnt <= r_cout_cnt + 16'd1;
    end
  end

  assign cout_cnt = r_cout_cnt;
`endif

endmodule

// File: tb/tb_full_adder.sv
// ---------------------------------------------------------------------------
// tb_full_adder
//   Drives a WIDTH=1 and a WIDTH=8 instance of full_adder from shared control
//   (rst_n, cin, in_valid). A reference model built on plain integer addition
//   predicts every output; a negedge compare process checks both instances
//   each cycle, and directed steps pin the model with hand-computed literals.
//   Define FULL_ADDER_STATS_EN to also exercise cout_cnt.
// ---------------------------------------------------------------------------
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cin;
  logic       in_valid;
  logic       a1, b1;
  logic [7:0] a8, b8;

  logic       s1, c1, sq1, cq1, v1;
  logic [7:0] s8, sq8;
  logic       c8, cq8, v8;
`ifdef FULL_ADDER_STATS_EN
  logic [15:0] cnt1, cnt8;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state for the registered path.
  logic [1:0] m1_q;   // {cout_q, sum_q} of the 1-bit instance
  logic [8:0] m8_q;   // {cout_q, sum_q} of the 8-bit instance
  logic       m_vld;
  int         m1_cnt;
  int         m8_cnt;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_fa1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a1),
    .b        (b1),
    .cin      (cin),
    .in_valid (in_valid),
    .sum      (s1),
    .cout     (c1),
    .sum_q    (sq1),
    .cout_q   (cq1),
    .out_valid(v1)
`ifdef FULL_ADDER_STATS_EN
    ,
    .cout_cnt (cnt1)
`endif
  );

  full_adder #(.WIDTH(8)) u_fa8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a8),
    .b        (b8),
    .cin      (cin),
    .in_valid (in_valid),
    .sum      (s8),
    .cout     (c8),
    .sum_q    (sq8),
    .cout_q   (cq8),
    .out_valid(v8)
`ifdef FULL_ADDER_STATS_EN
    ,
    .cout_cnt (cnt8)
`endif
  );

  function automatic logic [1:0] ref1(input logic x, input logic y, input logic ci);
    return 2'(x) + 2'(y) + 2'(ci);
  endfunction

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    return 9'(x) + 9'(y) + 9'(ci);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the registered path and the carry counter.
  always @(posedge clk) begin
    if (!rst_n) begin
      m1_q   <= '0;
      m8_q   <= '0;
      m_vld  <= 1'b0;
      m1_cnt <= 0;
      m8_cnt <= 0;
    end else if (in_valid) begin
      m1_q  <= ref1(a1, b1, cin);
      m8_q  <= ref8(a8, b8, cin);
      m_vld <= 1'b1;
      if (ref1(a1, b1, cin) >= 2'd2) m1_cnt <= (m1_cnt < 65535) ? m1_cnt + 1 : 65535;
      if (ref8(a8, b8, cin) >= 9'd256) m8_cnt <= (m8_cnt < 65535) ? m8_cnt + 1 : 65535;
    end else begin
      m_vld <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("comb1", 64'({c1, s1}), 64'(ref1(a1, b1, cin)));
      check("comb8", 64'({c8, s8}), 64'(ref8(a8, b8, cin)));
      check("vld1", 64'(v1), 64'(m_vld));
      check("vld8", 64'(v8), 64'(m_vld));
      check("reg1", 64'({cq1, sq1}), 64'(m1_q));
      check("reg8", 64'({cq8, sq8}), 64'(m8_q));
`ifdef FULL_ADDER_STATS_EN
      check("cnt1", 64'(cnt1), 64'(m1_cnt));
      check("cnt8", 64'(cnt8), 64'(m8_cnt));
`endif
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tt_sum;
    logic [7:0] tt_cout;
    logic [2:0] abc;
    tt_sum  = 8'b1001_0110;  // bit i = sum for {a,b,cin} == i
    tt_cout = 8'b1110_1000;  // bit i = cout for {a,b,cin} == i

    // Reset held for two edges with valid, all-ones operands.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF;
    repeat (2) begin
      step();
      check("rst_vld", 64'(v1), 64'(0));
      check("rst_sq", 64'(sq1), 64'(0));
      check("rst_cq", 64'(cq1), 64'(0));
      check("rst_comb_s", 64'(s1), 64'(1));
      check("rst_comb_c", 64'(c1), 64'(1));
    end

    // 1-bit truth table, operands changed every 4 time units.
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      {a1, b1, cin} = abc;
      #1;
      check($sformatf("tt_sum_%0d", i), 64'(s1), 64'(tt_sum[i]));
      check($sformatf("tt_cout_%0d", i), 64'(c1), 64'(tt_cout[i]));
      #3;
    end

    step();
    chk_en = 1'b1;

    // 8-bit carry boundaries.
    a8 = 8'hFF; b8 = 8'h01; cin = 1'b0;
    #1;
    check("w8_ff_01", 64'({c8, s8}), 64'h100);
    a8 = 8'h7F; b8 = 8'h80; cin = 1'b1;
    #1;
    check("w8_7f_80", 64'({c8, s8}), 64'h100);

    // Single registered transaction, then hold.
    step();
    in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b0; cin = 1'b1;
    step();
    check("one_sq", 64'(sq1), 64'(0));
    check("one_cq", 64'(cq1), 64'(1));
    check("one_vld", 64'(v1), 64'(1));
    in_valid = 1'b0;
    a1 = 1'b1; b1 = 1'b1; cin = 1'b1;
    step();
    check("hold_vld", 64'(v1), 64'(0));
    check("hold_q", 64'({cq1, sq1}), 64'(2'b10));

    // Back-to-back valid operand sets 001, 110, 000.
    in_valid = 1'b1;
    {a1, b1, cin} = 3'b001;
    step();
    check("b2b_0", 64'({sq1, cq1}), 64'(2'b10));
    {a1, b1, cin} = 3'b110;
    step();
    check("b2b_1", 64'({sq1, cq1}), 64'(2'b01));
    {a1, b1, cin} = 3'b000;
    step();
    check("b2b_2", 64'({sq1, cq1}), 64'(2'b00));
    check("b2b_vld", 64'(v1), 64'(1));

    // Randomized traffic with occasional mid-stream reset.
    repeat (1500) begin
      a1       = 1'($urandom);
      b1       = 1'($urandom);
      cin      = 1'($urandom);
      a8       = 8'($urandom);
      b8       = 8'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 39) != 0);
      step();
    end
    rst_n = 1'b1;

`ifdef FULL_ADDER_STATS_EN
    // Five carry-producing valid sets, then reset.
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin = 1'b0;
    a8 = 8'hFF; b8 = 8'h01;
    repeat (5) step();
    in_valid = 1'b0;
    step();
    check("cnt1_five", 64'(cnt1), 64'(5));
    check("cnt8_five", 64'(cnt8), 64'(5));
    rst_n = 1'b0;
    step();
    check("cnt1_rst", 64'(cnt1), 64'(0));
    check("cnt8_rst", 64'(cnt8), 64'(0));

    // Drive past the counter ceiling to see it saturate.
    rst_n    = 1'b1;
    in_valid = 1'b1;
    repeat (65540) step();
    check("cnt1_sat", 64'(cnt1), 64'hFFFF);
    check("cnt8_sat", 64'(cnt8), 64'hFFFF);
    in_valid = 1'b0;
`endif

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Parameterised ripple-carry full adder with a combinational result path and a one-cycle registered result path with valid qualification. The default width of 1 gives the classic single-bit full adder (a + b + cin -> sum, cout). It is a leaf arithmetic cell for datapath blocks that need either an immediate or a clock-aligned sum.

## Interface
Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1 to 64).

Ports:
- clk  input  1  rising-edge clock; the single clock of the block.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry in.
- in_valid  input  1  qualifies a, b and cin for the registered path.
- sum  output  WIDTH  combinational sum, (a + b + cin) mod 2^WIDTH.
- cout  output  1  combinational carry out, bit WIDTH of a + b + cin.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry out.
- out_valid  output  1  sum_q/cout_q hold a fresh result this cycle.
- cout_cnt  output  16  saturating count of valid carry-outs (present only with FULL_ADDER_STATS_EN).

## Operation
- Combinational path: the block is a ripple chain of WIDTH single-bit cells.
  - Each bit i computes s_i = a_i ^ b_i ^ c_i.
  - Each bit i computes c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = cin; cout = c_WIDTH.
- sum and cout depend only on a, b and cin. They are unaffected by clk, rst_n or in_valid.
- With WIDTH=1 the truth table is:
  - 000->s0 c0; 001->s1 c0; 010->s1 c0; 011->s0 c1.
  - 100->s1 c0; 101->s0 c1; 110->s0 c1; 111->s1 c1.
- Registered path, updated on each rising clk edge:
  - If rst_n=0: sum_q=0, cout_q=0, out_valid=0.
  - Else if in_valid=1: sum_q<=sum, cout_q<=cout, out_valid<=1.
  - Else: sum_q and cout_q hold their values, and out_valid<=0.
- Inputs are unknown or X-free assumptions are not made: X on any operand bit propagates to sum and cout.

## Timing
- Combinational path: zero-cycle latency, purely combinational.
- Registered path: latency of exactly 1 cycle. A result presented with in_valid at edge N appears on sum_q/cout_q with out_valid=1 after edge N.
- No backpressure; a new operand set can be accepted every cycle.
- Reset values: sum_q=0, cout_q=0, out_valid=0, cout_cnt=0.
- Reset has priority over in_valid on the same edge; the operands on that edge are discarded.
- Reset asserted mid-stream clears the registered path on the next edge. The first result after release appears one cycle after the first in_valid.

## Configuration
- Macro FULL_ADDER_STATS_EN.
- Defined:
  - Port cout_cnt exists.
  - On each edge with rst_n=1, in_valid=1 and cout=1, cout_cnt increments by 1 and saturates at 16'hFFFF.
  - rst_n=0 clears cout_cnt to 0.
- Not defined: port cout_cnt and its counter logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=1, apply all 8 combinations of a/b/cin, 4 time units apart -> sum/cout match the truth table immediately (e.g. 011 -> sum=0, cout=1; 111 -> sum=1, cout=1).
- rst_n=0 for 2 edges with in_valid=1 and a=b=cin=1 -> sum_q=0, cout_q=0, out_valid=0. Combinational sum=1, cout=1 throughout.
- rst_n=1, in_valid=1, a=1, b=0, cin=1 at edge N -> after edge N: sum_q=0, cout_q=1, out_valid=1. Drop in_valid at edge N+1 -> out_valid=0, sum_q/cout_q held.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. With a=8'h7F, b=8'h80, cin=1 -> sum=8'h00, cout=1.
- Back-to-back in_valid over 3 edges with 001, 110, 000 -> sum_q/cout_q sequence (1,0), (0,1), (0,0), each one edge later.
- With FULL_ADDER_STATS_EN: 5 valid carry-producing inputs followed by reset -> cout_cnt=5, then 0. Forced near-max count -> saturates at 16'hFFFF.
